// File: rtl/cen_frac_gen.sv
// Fractional clock-enable generator: one phase accumulator per channel emits a
// one-cycle enable on every overflow, plus a lock indicator that tracks how long
// the configuration has been stable.
`timescale 1ns/1ps
module cen_frac_gen #(
    parameter int          NUM_CH      = 3,
    parameter int          ACC_W       = 16,
    parameter int          LOCK_CYCLES = 256,
    parameter int unsigned INC_DEFAULT = 2**(ACC_W-2),
    localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              align,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [ACC_W-1:0]  wr_inc,
    output logic              wr_ack,
    output logic [NUM_CH-1:0] cen,
    output logic              locked
);

    localparam logic [ACC_W-1:0] INC_INIT = INC_DEFAULT[ACC_W-1:0];
    localparam logic [15:0]      LOCK_MAX = LOCK_CYCLES[15:0];
    localparam logic [31:0]      NUM_CH_U = NUM_CH;

    logic [ACC_W-1:0]  acc_r [NUM_CH];
    logic [ACC_W-1:0]  inc_r [NUM_CH];
    logic [ACC_W:0]    sum_s [NUM_CH];
    logic [NUM_CH-1:0] cen_r;
    logic              wr_ack_r;
    logic              locked_r;
    logic [15:0]       lock_cnt_r;
    logic [15:0]       lock_cnt_nxt_s;
    logic              wr_accept_s;
    logic              lock_clr_s;

    // Write qualification and per-channel carry-extended sums.
    always_comb begin
        wr_accept_s = wr_en && ({{(32-CH_W){1'b0}}, wr_ch} < NUM_CH_U);
        for (int i = 0; i < NUM_CH; i++) begin
            sum_s[i] = {1'b0, acc_r[i]} + {1'b0, inc_r[i]};
        end
    end

    // Saturating lock counter next value; any accepted write or align restarts it.
    always_comb begin
        lock_clr_s     = wr_accept_s || align;
        lock_cnt_nxt_s = lock_cnt_r;
        if (lock_clr_s) begin
            lock_cnt_nxt_s = 16'd0;
        end else if (lock_cnt_r != LOCK_MAX) begin
            lock_cnt_nxt_s = lock_cnt_r + 16'd1;
        end else begin
            lock_cnt_nxt_s = lock_cnt_r;
        end
    end

    // Accumulators and enable pulses; align overrides the run enable.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_r[i] <= '0;
            end
            cen_r <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (align) begin
                    acc_r[i] <= '0;
                    cen_r[i] <= 1'b0;
                end else if (ch_en[i]) begin
                    acc_r[i] <= sum_s[i][ACC_W-1:0];
                    cen_r[i] <= sum_s[i][ACC_W];
                end else begin
                    cen_r[i] <= 1'b0;
                end
            end
        end
    end

    // Increment registers; the sum on the writing edge still sees the old value.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                inc_r[i] <= INC_INIT;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_accept_s && (wr_ch == CH_W'(i))) begin
                    inc_r[i] <= wr_inc;
                end
            end
        end
    end

    // Write acknowledge, lock counter and lock flag.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack_r   <= 1'b0;
            lock_cnt_r <= 16'd0;
            locked_r   <= 1'b0;
        end else begin
            wr_ack_r   <= wr_accept_s;
            lock_cnt_r <= lock_cnt_nxt_s;
            locked_r   <= (lock_cnt_nxt_s == LOCK_MAX);
        end
    end

    assign cen    = cen_r;
    assign wr_ack = wr_ack_r;
    assign locked = locked_r;

endmodule

// File: tb/tb_cen_frac_gen.sv
// Directed bench for cen_frac_gen at default parameters: rates, writes,
// align, lock timing and asynchronous reset.
`timescale 1ns/1ps
module tb_cen_frac_gen;

    logic        refclk = 1'b0;
    logic        rst_n;
    logic [2:0]  ch_en;
    logic        align;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [15:0] wr_inc;
    logic        wr_ack;
    logic [2:0]  cen;
    logic        locked;

    int n_cmp = 0;
    int n_err = 0;

    always #5 refclk = ~refclk;

    cen_frac_gen #(
        .NUM_CH(3), .ACC_W(16), .LOCK_CYCLES(256)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .ch_en(ch_en), .align(align),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_inc(wr_inc), .wr_ack(wr_ack),
        .cen(cen), .locked(locked)
    );

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ch_en = 3'b000; align = 1'b0;
        wr_en = 1'b0; wr_ch = 2'd0; wr_inc = 16'h0000;
        #2;
        n_cmp++; if ({cen, wr_ack, locked} !== 5'b00000) begin n_err++;
            $display("FAIL reset_outputs: got %b expected 00000", {cen, wr_ack, locked}); end
        ch_en = 3'b111;
        for (int k = 0; k < 3; k++) tick();
        n_cmp++; if (cen !== 3'b000) begin n_err++;
            $display("FAIL reset_hold_cen: got %b expected 000", cen); end
        rst_n = 1'b1;
    endtask

    task automatic test_default_rate();
        logic [2:0] exp_cen;
        for (int k = 1; k <= 260; k++) begin
            tick();
            exp_cen = ((k % 4) == 0) ? 3'b111 : 3'b000;
            n_cmp++; if (cen !== exp_cen) begin n_err++;
                $display("FAIL default_cen edge %0d: got %b expected %b", k, cen, exp_cen); end
            n_cmp++; if (locked !== (k >= 256)) begin n_err++;
                $display("FAIL default_locked edge %0d: got %b expected %b", k, locked, (k >= 256)); end
        end
    endtask

    task automatic test_write_rate();
        int cnt1 = 0;
        wr_en = 1'b1; wr_ch = 2'd1; wr_inc = 16'h5556;
        tick();
        wr_en = 1'b0;
        n_cmp++; if (wr_ack !== 1'b1) begin n_err++;
            $display("FAIL write_ack: got %b expected 1", wr_ack); end
        n_cmp++; if (locked !== 1'b0) begin n_err++;
            $display("FAIL write_lock_drop: got %b expected 0", locked); end
        for (int j = 1; j <= 3000; j++) begin
            tick();
            if (cen[1]) cnt1++;
            if (j == 1) begin
                n_cmp++; if (wr_ack !== 1'b0) begin n_err++;
                    $display("FAIL write_ack_one_cycle: got %b expected 0", wr_ack); end
            end
            if (j == 255 || j == 256) begin
                n_cmp++; if (locked !== (j == 256)) begin n_err++;
                    $display("FAIL write_relock cycle %0d: got %b expected %b", j, locked, (j == 256)); end
            end
        end
        n_cmp++; if (cnt1 < 999 || cnt1 > 1001) begin n_err++;
            $display("FAIL write_rate_ch1: got %0d expected 999..1001", cnt1); end
    endtask

    task automatic test_bad_write();
        int c0 = 0; int c1 = 0; int c2 = 0;
        wr_en = 1'b1; wr_ch = 2'd3; wr_inc = 16'h0000;
        tick();
        wr_en = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            tick();
            if (cen[0]) c0++;
            if (cen[1]) c1++;
            if (cen[2]) c2++;
            n_cmp++; if ({wr_ack, locked} !== 2'b01) begin n_err++;
                $display("FAIL bad_write_ack_lock cycle %0d: got %b expected 01", j, {wr_ack, locked}); end
        end
        n_cmp++; if (c0 !== 10 || c2 !== 10) begin n_err++;
            $display("FAIL bad_write_rates: got c0=%0d c2=%0d expected 10 10", c0, c2); end
        n_cmp++; if (c1 < 13 || c1 > 14) begin n_err++;
            $display("FAIL bad_write_rate_ch1: got %0d expected 13..14", c1); end
    endtask

    task automatic test_extreme_inc();
        int hi0 = 0; int lo2 = 0;
        wr_en = 1'b1; wr_ch = 2'd0; wr_inc = 16'h0000;
        tick();
        n_cmp++; if (wr_ack !== 1'b1) begin n_err++;
            $display("FAIL b2b_ack_first: got %b expected 1", wr_ack); end
        wr_ch = 2'd2; wr_inc = 16'hFFFF;
        tick();
        wr_en = 1'b0;
        n_cmp++; if (wr_ack !== 1'b1) begin n_err++;
            $display("FAIL b2b_ack_second: got %b expected 1", wr_ack); end
        tick();
        n_cmp++; if (wr_ack !== 1'b0) begin n_err++;
            $display("FAIL b2b_ack_end: got %b expected 0", wr_ack); end
        align = 1'b1;
        tick();
        align = 1'b0;
        n_cmp++; if (cen !== 3'b000) begin n_err++;
            $display("FAIL extreme_align_cen: got %b expected 000", cen); end
        for (int j = 1; j <= 65536; j++) begin
            tick();
            if (cen[0]) hi0++;
            if (!cen[2]) lo2++;
            if (j == 1 || j == 2) begin
                n_cmp++; if (cen[2] !== (j == 2)) begin n_err++;
                    $display("FAIL max_inc_start cycle %0d: got %b expected %b", j, cen[2], (j == 2)); end
            end
        end
        n_cmp++; if (hi0 !== 0) begin n_err++;
            $display("FAIL zero_inc_pulses: got %0d expected 0", hi0); end
        n_cmp++; if (lo2 !== 1) begin n_err++;
            $display("FAIL max_inc_low_cycles: got %0d expected 1", lo2); end
    endtask

    task automatic test_align_write();
        logic [2:0] exp_cen;
        wr_en = 1'b1; wr_ch = 2'd1; wr_inc = 16'h4000;
        tick();
        wr_ch = 2'd2;
        tick();
        wr_en = 1'b0; ch_en = 3'b010;
        tick();
        ch_en = 3'b100;
        tick(); tick();
        ch_en = 3'b111;
        tick(); tick(); tick();
        align = 1'b1; wr_en = 1'b1; wr_ch = 2'd0; wr_inc = 16'h4000;
        tick();
        align = 1'b0; wr_en = 1'b0;
        n_cmp++; if ({cen, wr_ack, locked} !== 5'b00010) begin n_err++;
            $display("FAIL align_write: got %b expected 00010", {cen, wr_ack, locked}); end
        for (int j = 1; j <= 260; j++) begin
            tick();
            exp_cen = ((j % 4) == 0) ? 3'b111 : 3'b000;
            n_cmp++; if (cen !== exp_cen) begin n_err++;
                $display("FAIL align_phase cycle %0d: got %b expected %b", j, cen, exp_cen); end
            n_cmp++; if (locked !== (j >= 256)) begin n_err++;
                $display("FAIL align_relock cycle %0d: got %b expected %b", j, locked, (j >= 256)); end
        end
        wr_en = 1'b1; wr_ch = 2'd0; wr_inc = 16'h8000;
        tick();
        wr_en = 1'b0;
        n_cmp++; if ({cen, wr_ack, locked} !== 5'b00010) begin n_err++;
            $display("FAIL old_inc_edge: got %b expected 00010", {cen, wr_ack, locked}); end
        tick();
        n_cmp++; if (cen !== 3'b000) begin n_err++;
            $display("FAIL old_inc_plus1: got %b expected 000", cen); end
        tick();
        n_cmp++; if (cen !== 3'b001) begin n_err++;
            $display("FAIL old_inc_plus2: got %b expected 001", cen); end
        tick();
        n_cmp++; if (cen !== 3'b110) begin n_err++;
            $display("FAIL old_inc_plus3: got %b expected 110", cen); end
    endtask

    task automatic test_mid_reset();
        logic [2:0] exp_cen;
        for (int k = 1; k <= 260; k++) begin
            ch_en = k[2:0];
            tick();
        end
        n_cmp++; if (locked !== 1'b1) begin n_err++;
            $display("FAIL pre_reset_locked: got %b expected 1", locked); end
        ch_en = 3'b111; wr_en = 1'b1; wr_ch = 2'd1; wr_inc = 16'h0000;
        tick();
        n_cmp++; if ({wr_ack, locked} !== 2'b10) begin n_err++;
            $display("FAIL pre_reset_write: got %b expected 10", {wr_ack, locked}); end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({cen, wr_ack, locked} !== 5'b00000) begin n_err++;
            $display("FAIL async_reset: got %b expected 00000", {cen, wr_ack, locked}); end
        ch_en = 3'b101;
        tick();
        n_cmp++; if ({cen, wr_ack, locked} !== 5'b00000) begin n_err++;
            $display("FAIL reset_held: got %b expected 00000", {cen, wr_ack, locked}); end
        rst_n = 1'b1; wr_en = 1'b0; ch_en = 3'b111;
        for (int k = 1; k <= 260; k++) begin
            tick();
            exp_cen = ((k % 4) == 0) ? 3'b111 : 3'b000;
            n_cmp++; if (cen !== exp_cen) begin n_err++;
                $display("FAIL post_reset_cen edge %0d: got %b expected %b", k, cen, exp_cen); end
            n_cmp++; if (locked !== (k >= 256)) begin n_err++;
                $display("FAIL post_reset_locked edge %0d: got %b expected %b", k, locked, (k >= 256)); end
        end
    endtask

    initial begin
        test_reset();
        test_default_rate();
        test_write_rate();
        test_bad_write();
        test_extreme_inc();
        test_align_write();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
